ssd1306_spi_axil: RTL

- AXI4-Lite slave that replaces the fixed four-register SSD1306 driver front end.
- Parametrised register file: CTRL, STATUS, two push ports and NUM_SCRATCH scratch registers.
- Command/data byte FIFO of depth FIFO_DEPTH.
- Mode-0 SPI serializer with programmable clock divider that drives the SSD1306 CS/DC/SCLK/MOSI pins.
- Sits between the PS AXI interconnect and the OLED pins.

---
 rtl/ssd1306_spi_axil_if.sv | 37 +++
 rtl/ssd1306_spi_axil.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_axil_if.sv
// AXI4-Lite bus bundle for the SSD1306 SPI front end.
interface ssd1306_spi_axil_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ssd1306_spi_axil.sv
// AXI4-Lite register front end, byte FIFO and mode-0 SPI serializer for an SSD1306 OLED.
// Optional interrupt output enabled by defining SSD1306_SPI_IRQ_EN.
module ssd1306_spi_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH         = 16,
  parameter int NUM_SCRATCH        = 2,
  parameter int DIV_RESET          = 4
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  ssd1306_spi_axil_if.slave s_axi,
  output logic oled_cs_n,
  output logic oled_dc,
  output logic oled_sclk,
  output logic oled_mosi
`ifdef SSD1306_SPI_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int IW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NS1 = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_n;

  logic awready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
  logic wr_fire, rd_fire;
  logic [IW-1:0] widx, ridx;

  logic en, flush_q, ovf;
  logic [7:0] div, thr;
  logic [31:0] scratch [NS1];

  logic [8:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, level;
  logic [8:0] level9, push_dat, fifo_q;
  logic full, empty, push_req, pop;

  logic [7:0] div_q, hp_cnt, shreg;
  logic [3:0] edge_cnt;
  logic dc_lat, hp_done, busy, irq_bit;
  logic cs_n_q, dc_q, sclk_q, mosi_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // ---------------- AXI handshakes ----------------
  assign wr_fire = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = arready_q & s_axi.S_AXI_ARVALID;
  assign widx    = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx    = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= !awready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q;
      if (wr_fire)                 bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= !arready_q && s_axi.S_AXI_ARVALID && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------- register file ----------------
  assign push_req = wr_fire && s_axi.S_AXI_WSTRB[0] && (widx == IW'(2) || widx == IW'(3));
  assign push_dat = {widx == IW'(3), s_axi.S_AXI_WDATA[7:0]};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      en      <= 1'b0;
      flush_q <= 1'b0;
      ovf     <= 1'b0;
      div     <= 8'(DIV_RESET);
      thr     <= 8'd0;
      for (int k = 0; k < NS1; k++) scratch[k] <= '0;
    end else begin
      flush_q <= 1'b0;
      if (wr_fire) begin
        if (widx == IW'(0)) begin
          if (s_axi.S_AXI_WSTRB[0]) begin
            en      <= s_axi.S_AXI_WDATA[0];
            flush_q <= s_axi.S_AXI_WDATA[1];
          end
          if (s_axi.S_AXI_WSTRB[1]) div <= s_axi.S_AXI_WDATA[15:8];
          if (s_axi.S_AXI_WSTRB[2]) thr <= s_axi.S_AXI_WDATA[23:16];
        end
        if (widx == IW'(1) && s_axi.S_AXI_WSTRB[2] && s_axi.S_AXI_WDATA[16]) ovf <= 1'b0;
        for (int k = 0; k < NUM_SCRATCH; k++)
          if (widx == IW'(4 + k))
            for (int b = 0; b < 4; b++)
              if (s_axi.S_AXI_WSTRB[b]) scratch[k][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
      // A push into a full FIFO is lost even if the serializer pops this cycle.
      if (push_req && full) ovf <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ridx == IW'(0)) rd_mux = {8'd0, thr, div, 7'd0, en};
    if (ridx == IW'(1)) rd_mux = {14'd0, irq_bit, ovf, level9[7:0], 5'd0, empty, full, busy};
    for (int k = 0; k < NUM_SCRATCH; k++)
      if (ridx == IW'(4 + k)) rd_mux = scratch[k];
  end

  // ---------------- byte FIFO ----------------
  assign level  = wr_ptr - rd_ptr;
  assign level9 = 9'(level);
  assign full   = (level == PW'(FIFO_DEPTH));
  assign empty  = (level == '0);
  assign fifo_q = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge S_AXI_ACLK)
    if (push_req && !full) mem[wr_ptr[AW-1:0]] <= push_dat;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_req && !full) wr_ptr <= wr_ptr + PW'(1);
      if (flush_q)  rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---------------- serializer ----------------
  assign hp_done = (hp_cnt == div_q);
  assign busy    = (state != IDLE);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (en && !empty && !flush_q) begin
               pop     = 1'b1;
               state_n = SETUP;
             end
      SETUP: if (hp_done) state_n = SHIFT;
      SHIFT: if (hp_done && edge_cnt == 4'd15) state_n = HOLD;
      HOLD:  if (hp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pins are registered from the current state, so every phase keeps its full length.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      hp_cnt   <= 8'd0;
      edge_cnt <= 4'd0;
      shreg    <= 8'd0;
      dc_lat   <= 1'b0;
      div_q    <= 8'd0;
      cs_n_q   <= 1'b1;
      dc_q     <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        hp_cnt   <= 8'd0;
        edge_cnt <= 4'd0;
        if (pop) begin
          shreg  <= fifo_q[7:0];
          dc_lat <= fifo_q[8];
          div_q  <= div;
        end
      end else begin
        hp_cnt <= hp_done ? 8'd0 : hp_cnt + 8'd1;
        // Even edge_cnt is the high half; leaving it is the fall that advances mosi.
        if (state == SHIFT && hp_done) begin
          edge_cnt <= edge_cnt + 4'd1;
          if (!edge_cnt[0]) shreg <= {shreg[6:0], 1'b0};
        end
      end
      cs_n_q <= !(state == SETUP || state == SHIFT);
      sclk_q <= (state == SHIFT) && !edge_cnt[0];
      mosi_q <= (state == SETUP || state == SHIFT) && shreg[7];
      dc_q   <= dc_lat;
    end
  end

  assign oled_cs_n = cs_n_q;
  assign oled_dc   = dc_q;
  assign oled_sclk = sclk_q;
  assign oled_mosi = mosi_q;

`ifdef SSD1306_SPI_IRQ_EN
  logic irq_q;
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_q <= 1'b0;
    else              irq_q <= en && (level9 <= {1'b0, thr}) && !busy;
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

endmodule
